demux_stepper: RTL

- Sequential counterpart of the board's 2:1 mux exercises: one input is steered onto one of N_OUT outputs instead of selecting one of many.
- A debounced "step" button advances a registered channel select.
- A debounced "data" button is routed to the selected output register; unselected outputs hold their last value.
- Top-level block for the EPM240 board. Buttons and LEDs are active-low at the pins.

---
 rtl/demux_stepper.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/demux_stepper.sv
// demux_stepper: one debounced data button steered onto one of N_OUT LED channels,
//   with a debounced step button advancing the channel select.
// Latency: a held key pin change reaches led_out_n / led_sel_n after 2 + DEBOUNCE_CYCLES + 1 edges.
// Backpressure: none; free-running, every output is a register and is updated every cycle.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset (priority over all other logic)
//   key_data_n  data button, active-low, asynchronous to clk
//   key_step_n  step button, active-low, asynchronous to clk
//   led_out_n   demux output channels, active-low (0 = LED on)
//   led_sel_n   one-hot current select, active-low
//
// Optional feature: define DEMUX_AUTOSTEP_EN to add a free-running auto-step counter
// that advances the select every AUTO_PERIOD cycles; a step press restarts that counter.

module demux_stepper #(
  parameter int N_OUT           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_PERIOD     = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_data_n,
  input  logic             key_step_n,
  output logic [N_OUT-1:0] led_out_n,
  output logic [N_OUT-1:0] led_sel_n
);

  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Key index 0 = data, 1 = step. Levels are kept in pin polarity (1 = released).
  localparam int KEY_DATA = 0;
  localparam int KEY_STEP = 1;

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_db_lvl;
  logic [CNT_W-1:0] r_db_cnt [2];
  logic             r_step_prev;
  logic [SEL_W-1:0] r_sel;
  logic [N_OUT-1:0] r_sel_oh;
  logic [N_OUT-1:0] r_out;

  logic             w_step_pulse;
  logic             w_auto_pulse;
  logic             w_advance;
  logic             w_data_pressed;

  // Two-flop synchronizers; reset to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= {key_step_n, key_data_n};
      r_sync2 <= r_sync1;
    end
  end

  // Debouncers: the counter runs only while the synchronized level disagrees with the
  // accepted level; any agreement (a bounce back) clears it. The level flips on the
  // edge where the count would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_lvl <= 2'b11;
      for (int k = 0; k < 2; k++) begin
        r_db_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] != r_db_lvl[k]) begin
          if (r_db_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db_lvl[k] <= r_sync2[k];
            r_db_cnt[k] <= '0;
          end else begin
            r_db_cnt[k] <= r_db_cnt[k] + CNT_W'(1);
          end
        end else begin
          r_db_cnt[k] <= '0;
        end
      end
    end
  end

  // Step edge detector: pulse only on debounced released -> pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_prev <= 1'b1;
    end else begin
      r_step_prev <= r_db_lvl[KEY_STEP];
    end
  end

  assign w_step_pulse   = r_step_prev & ~r_db_lvl[KEY_STEP];
  assign w_data_pressed = ~r_db_lvl[KEY_DATA];

`ifdef DEMUX_AUTOSTEP_EN
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  logic [AUTO_W-1:0] r_auto_cnt;

  assign w_auto_pulse = (r_auto_cnt == AUTO_W'(AUTO_PERIOD - 1));

  // A manual step restarts the interval so the next auto step is a full period away.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_auto_cnt <= '0;
    end else if (w_step_pulse || w_auto_pulse) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
    end
  end
`else
  // Without auto-step the select moves only on the step button.
  assign w_auto_pulse = 1'b0 & (AUTO_PERIOD != 0);
`endif

  // Coincident auto and manual pulses merge into a single increment.
  assign w_advance = w_step_pulse | w_auto_pulse;

  // Select register with explicit wrap (correct for non-power-of-two N_OUT).
  // The one-hot copy is registered so led_sel_n is driven straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel    <= '0;
      r_sel_oh <= N_OUT'(1);
    end else if (w_advance) begin
      if (r_sel == SEL_W'(N_OUT - 1)) begin
        r_sel    <= '0;
        r_sel_oh <= N_OUT'(1);
      end else begin
        r_sel    <= r_sel + SEL_W'(1);
        r_sel_oh <= r_sel_oh << 1;
      end
    end
  end

  // Output registers: only the currently selected channel follows the data key.
  // The write uses the pre-update select, so on a step edge the old channel takes
  // the last sample and the new channel starts following on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (r_sel == SEL_W'(i)) begin
          r_out[i] <= w_data_pressed;
        end
      end
    end
  end

  assign led_out_n = ~r_out;
  assign led_sel_n = ~r_sel_oh;

endmodule
